// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 boot path.
// SYNC_BYTE marks the start of a loader frame; loader_state_e is the loader FSM encoding.
package mips16_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//   rx_data/rx_valid/rx_ready : host byte stream, transfer when valid & ready
//   imem_we/imem_addr/imem_wdata : one-cycle word write into instruction memory
// slave  = loader side, master = host / memory side.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_timeout.sv
// Idle-cycle watchdog for the loader.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count (byte accepted or loader not inside a frame)
//   enable     : count this cycle if not cleared
//   expired    : this idle cycle is the TIMEOUT_CYC-th since the last clear
module loader_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    // Flagged one count early so the FSM leaves on the edge the count would hit TIMEOUT_CYC.
    assign expired = enable && !clear && (count == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses SYNC, LEN_HI, LEN_LO, LEN x (HI, LO), CSUM,
// writes big-endian words to instruction memory from address 0 and releases
// the core's reset once the XOR checksum verifies.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : byte stream in, instruction-memory write out
//   cpu_reset  : held high until a frame verifies
//   done / err : last frame verified / rejected
module imem_loader
    import mips16_pkg::*;
#(
    parameter int MAX_WORDS   = 256,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          done,
    output logic          err
);
    loader_state_e state;
    logic [15:0]   len;
    logic [15:0]   index;
    logic [7:0]    len_hi;
    logic [7:0]    data_hi;
    logic [7:0]    csum;

    logic          accept;
    logic          active;
    logic          to_clear;
    logic          to_enable;
    logic          to_expired;
    logic [15:0]   len_rx;
    logic          len_bad;

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign active    = state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_WRITE, ST_CSUM};
    // WRITE never accepts a byte, so it neither counts nor clears the watchdog.
    assign to_enable = active && (state != ST_WRITE);
    assign to_clear  = accept || !active;
    assign len_rx    = {len_hi, bus.rx_data};
    assign len_bad   = (len_rx == 16'd0) || ({1'b0, len_rx} > 17'(MAX_WORDS));

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            bus.rx_ready   <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= 16'd0;
            bus.imem_wdata <= 16'd0;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            len            <= 16'd0;
            index          <= 16'd0;
            len_hi         <= 8'd0;
            data_hi        <= 8'd0;
            csum           <= 8'd0;
        end else begin
            bus.imem_we <= 1'b0;
            if (to_expired) begin
                state <= ST_ERR;
                err   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (accept && bus.rx_data == SYNC_BYTE) begin
                            state     <= ST_LEN_HI;
                            csum      <= 8'd0;
                            index     <= 16'd0;
                            done      <= 1'b0;
                            err       <= 1'b0;
                            cpu_reset <= 1'b1;
                        end
                    end
                    ST_LEN_HI: begin
                        if (accept) begin
                            len_hi <= bus.rx_data;
                            csum   <= csum ^ bus.rx_data;
                            state  <= ST_LEN_LO;
                        end
                    end
                    ST_LEN_LO: begin
                        if (accept) begin
                            len  <= len_rx;
                            csum <= csum ^ bus.rx_data;
                            if (len_bad) begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end else begin
                                state <= ST_DATA_HI;
                            end
                        end
                    end
                    ST_DATA_HI: begin
                        if (accept) begin
                            data_hi <= bus.rx_data;
                            csum    <= csum ^ bus.rx_data;
                            state   <= ST_DATA_LO;
                        end
                    end
                    ST_DATA_LO: begin
                        // Write strobe and ready drop are registered here so they line up with WRITE.
                        if (accept) begin
                            csum           <= csum ^ bus.rx_data;
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= {index[14:0], 1'b0};
                            bus.imem_wdata <= {data_hi, bus.rx_data};
                            bus.rx_ready   <= 1'b0;
                            state          <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        bus.rx_ready <= 1'b1;
                        index        <= index + 16'd1;
                        state        <= (index + 16'd1 == len) ? ST_CSUM : ST_DATA_HI;
                    end
                    ST_CSUM: begin
                        if (accept) begin
                            if (bus.rx_data == csum) begin
                                state     <= ST_DONE;
                                done      <= 1'b1;
                                cpu_reset <= 1'b0;
                            end else begin
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset;

    logic cpu_reset;
    logic done;
    logic err;

    imem_loader_if bus ();

    imem_loader #(
        .MAX_WORDS   (256),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int stalls = 0;
    logic [31:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write capture and the ready/WRITE relationship, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1)
            got_q.push_back({bus.imem_addr, bus.imem_wdata});
        if (reset === 1'b0)
            chk("ready_low_only_in_write", {31'd0, bus.rx_ready}, {31'd0, ~bus.imem_we});
    end

    // Called at a negedge; returns at the negedge after the transfer edge, valid left high.
    task automatic send(input logic [7:0] b);
        int n;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (bus.rx_ready !== 1'b1) begin
            chk("ready_wait", 32'd0, 32'd1);
            bus.rx_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e, input logic c);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, c});
    endtask

    // Reference model: a frame of n random words writes word i to byte address 2*i;
    // it verifies exactly when the trailing byte equals the XOR of all bytes after SYNC.
    task automatic run_frame(input int n, input bit corrupt, input int max_gap, input bit check_stalls);
        logic [7:0]  bytes[$];
        logic [31:0] exp_q[$];
        logic [15:0] w;
        logic [7:0]  cs;
        bytes.push_back(8'hA5);
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
            exp_q.push_back({16'(2 * i), w});
        end
        cs = 8'd0;
        for (int i = 1; i < bytes.size(); i++) cs ^= bytes[i];
        if (corrupt) cs ^= 8'(1 << $urandom_range(0, 7));
        bytes.push_back(cs);

        got_q.delete();
        stalls = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            send(bytes[i]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        idle(2);
        chk("write_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk("write_addr_data", got_q[i], exp_q[i]);
        chk_status(corrupt ? "bad_csum" : "good_frame", !corrupt, corrupt, corrupt);
        if (check_stalls) chk("stall_cycles", stalls, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        chk("rst_imem_addr", {16'd0, bus.imem_addr}, 32'd0);
        chk("rst_imem_wdata", {16'd0, bus.imem_wdata}, 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        // Two-word frame with write-latency check
        got_q.delete();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
        send(8'h34);
        chk("lat_we", {31'd0, bus.imem_we}, 32'd1);
        chk("lat_addr", {16'd0, bus.imem_addr}, 32'h0000);
        chk("lat_wdata", {16'd0, bus.imem_wdata}, 32'h1234);
        send(8'hAB); send(8'hCD); send(8'h42);
        chk_status("two_words", 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("two_words_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("two_words_w0", got_q[0], 32'h0000_1234);
            chk("two_words_w1", got_q[1], 32'h0002_ABCD);
        end

        // Same frame, wrong checksum
        got_q.delete();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
        send(8'h34); send(8'hAB); send(8'hCD); send(8'h43);
        chk_status("csum43", 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("csum43_count", got_q.size(), 2);

        // Bad lengths
        got_q.delete();
        send(8'hA5); send(8'h00); send(8'h00);
        chk_status("len0", 1'b0, 1'b1, 1'b1);
        send(8'hA5); send(8'h01); send(8'h01);
        chk_status("len257", 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("badlen_no_write", got_q.size(), 0);

        // Timeout after 16 idle cycles, then recovery
        send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
        idle(15);
        chk("timeout_early_err", {31'd0, err}, 32'd0);
        idle(1);
        chk_status("timeout", 1'b0, 1'b1, 1'b1);
        run_frame(1, 1'b0, 0, 1'b0);

        // Randomized frames with random idle gaps
        for (int k = 0; k < 6; k++)
            run_frame($urandom_range(1, 8), ($urandom_range(0, 2) == 0), 4, 1'b0);

        // Largest legal length
        run_frame(256, 1'b0, 0, 1'b0);

        // Continuous valid: one stall per word, no byte lost
        run_frame(5, 1'b0, 0, 1'b1);

        // Asynchronous reset mid-data, then bytes without SYNC are ignored
        send(8'hA5); send(8'h00); send(8'h03); send(8'h11); send(8'h22);
        idle(1);
        reset = 1'b1;
        #1;
        chk("arst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("arst_imem_we", {31'd0, bus.imem_we}, 32'd0);
        chk("arst_imem_addr", {16'd0, bus.imem_addr}, 32'd0);
        chk("arst_imem_wdata", {16'd0, bus.imem_wdata}, 32'd0);
        chk_status("arst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        got_q.delete();
        send(8'h5A); send(8'h00); send(8'h02); send(8'h12);
        send(8'h34); send(8'hAB); send(8'hCD); send(8'h42);
        idle(3);
        chk("nosync_no_write", got_q.size(), 0);
        chk_status("nosync", 1'b0, 1'b0, 1'b1);

        // Reload from DONE
        run_frame(2, 1'b0, 0, 1'b0);
        got_q.delete();
        send(8'hA5);
        chk_status("reload_sync", 1'b0, 1'b0, 1'b1);
        send(8'h00); send(8'h01); send(8'hBE); send(8'hEF);
        chk("reload_still_held", {31'd0, cpu_reset}, 32'd1);
        send(8'h00 ^ 8'h01 ^ 8'hBE ^ 8'hEF);
        chk_status("reload_done", 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("reload_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("reload_w0", got_q[0], 32'h0000_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the 16-bit single-cycle MIPS core. It receives a framed byte stream from a host link (UART RX or debug port) over a valid/ready handshake, assembles big-endian 16-bit instruction words, writes them into instruction memory at consecutive even byte addresses from 0x0000, and verifies a checksum. It holds the core in reset until a frame is loaded and verified.

## Interface
Parameters:
- MAX_WORDS, 256, largest accepted word count; larger lengths are rejected.
- TIMEOUT_CYC, 100000, maximum idle cycles allowed between accepted bytes inside a frame.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid and rx_ready are both high on a rising edge.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  16  byte address of the write, always even.
- imem_wdata  out  16  instruction word.
- cpu_reset  out  1  reset to the MIPS core; high until a frame verifies.
- done  out  1  last frame loaded and verified.
- err  out  1  last frame rejected.

## Operation
- Frame format: SYNC (0xA5), LEN_HI, LEN_LO, then LEN words as HI, LO byte pairs, then CSUM.
- CSUM is the 8-bit XOR of every byte after SYNC, excluding CSUM itself.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR: a 0xA5 byte moves to LEN_HI. Entering LEN_HI clears the checksum, word index, done and err, and sets cpu_reset=1. Any other byte is consumed and ignored.
- LEN_LO accept: if LEN==0 or LEN>MAX_WORDS, go to ERR. Otherwise go to DATA_HI.
- DATA_HI: latch the high byte. DATA_LO: latch the low byte and go to WRITE.
- WRITE: lasts one cycle. imem_we=1, imem_addr=index*2, imem_wdata={hi,lo}, rx_ready=0. Then increment the index and go to DATA_HI, or to CSUM if index+1==LEN.
- CSUM accept: on a match go to DONE (done=1, cpu_reset=0). On a mismatch go to ERR (err=1, cpu_reset stays 1).
- Timeout: in LEN_HI through CSUM (excluding WRITE), an idle counter clears on each accepted byte. When it reaches TIMEOUT_CYC, go to ERR.
- Words are written before verification. A failed frame leaves partial or stale contents, but the core stays in reset.
- rx_ready=1 in every state except WRITE.

## Timing
- Reset values: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, err=0, state IDLE.
- All outputs are registered or decoded from registered state. There is no combinational path from rx_* to any output.
- Write latency: imem_we is high in the cycle after the LO byte is accepted.
- Throughput: a word takes at least 3 cycles (HI, LO, WRITE).
- done/cpu_reset change in the cycle after the CSUM byte is accepted.
- Asynchronous reset mid-frame aborts immediately to the reset values. The next frame must start with SYNC.
- The idle counter is wide enough for TIMEOUT_CYC. Addresses wrap modulo 2^16, but this is unreachable because LEN≤MAX_WORDS.
- rx_valid held high during WRITE: no transfer occurs, and the byte is taken in the next cycle.

## Structure
- Shared package mips16_pkg: the SYNC_BYTE constant (0xA5) and the loader state enum.
- One sub-module, loader_timeout: a counter with clear, enable and expired outputs, parameterised by TIMEOUT_CYC.

## Test plan
- Load two words: send A5 00 02 12 34 AB CD 42 → writes (0x0000, 0x1234) then (0x0002, 0xABCD). Then done=1, cpu_reset=0, err=0.
- Same frame with CSUM 43 → both writes occur, then err=1, cpu_reset=1, done=0.
- Bad lengths: A5 00 00 gives err=1 after LEN_LO with no write. A5 01 01 with MAX_WORDS=256 gives err=1.
- Timeout (TIMEOUT_CYC=16): send A5 00 01 12 then hold rx_valid=0 → err=1 after 16 idle cycles. A following valid frame loads and sets done=1.
- Backpressure: keep rx_valid high continuously and check rx_ready=0 exactly in each WRITE cycle with no byte lost. Then pulse reset mid-data → all outputs return to reset values, and a non-A5 byte is ignored.
- Reload from DONE: send a new frame → cpu_reset rises on SYNC and falls after the new CSUM verifies.
